key_tone_sequencer: RTL and testbench

//  Sequences the piano's tone datapath from decoded PS/2 scancode bytes.
//  - Tracks make, break (F0) and extended (E0) prefixes, and selects one active note.
//  - Runs a half-period counter whose "count < limit-1" compare gates increment vs. wrap.
//  - Drives a square-wave speaker output.
//  - Sits between the PS/2 byte receiver and the speaker pin.

---
 rtl/key_tone_sequencer.sv | 154 +++++++++++++++
 tb/tb_key_tone_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/key_tone_sequencer.sv
// Key-driven tone sequencer: decodes PS/2 make/break/extended scancodes into one
// active note and generates that note's square wave from a half-period counter.
module key_tone_sequencer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CW     = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code,
    input  logic       code_valid,
    input  logic       enable,
    output logic       tone,
    output logic       note_active,
    output logic [2:0] note_idx
);

    localparam logic S_IDLE = 1'b0;
    localparam logic S_PLAY = 1'b1;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    // Note frequencies are given in millihertz so the rounding stays in integer math.
    function automatic logic [CW-1:0] half_period(input longint f_mhz);
        longint num;
        num = longint'(CLK_HZ) * 64'd1000 + f_mhz;
        return CW'(num / (64'd2 * f_mhz));
    endfunction

    localparam logic [CW-1:0] LIM_C4 = half_period(64'd261626);
    localparam logic [CW-1:0] LIM_D4 = half_period(64'd293665);
    localparam logic [CW-1:0] LIM_E4 = half_period(64'd329628);
    localparam logic [CW-1:0] LIM_F4 = half_period(64'd349228);
    localparam logic [CW-1:0] LIM_G4 = half_period(64'd391995);
    localparam logic [CW-1:0] LIM_A4 = half_period(64'd440000);
    localparam logic [CW-1:0] LIM_B4 = half_period(64'd493883);
    localparam logic [CW-1:0] LIM_C5 = half_period(64'd523251);

    logic          state_q, state_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tone_q, tone_d;

    logic          key_hit;
    logic [2:0]    key_idx;
    logic [CW-1:0] key_limit;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        key_hit = 1'b1;
        key_idx = 3'd0;
        case (code)
            8'h1C:   key_idx = 3'd0;
            8'h1B:   key_idx = 3'd1;
            8'h23:   key_idx = 3'd2;
            8'h2B:   key_idx = 3'd3;
            8'h34:   key_idx = 3'd4;
            8'h33:   key_idx = 3'd5;
            8'h3B:   key_idx = 3'd6;
            8'h42:   key_idx = 3'd7;
            default: key_hit = 1'b0;
        endcase
    end

    always_comb begin
        key_limit = LIM_C4;
        case (key_idx)
            3'd0:    key_limit = LIM_C4;
            3'd1:    key_limit = LIM_D4;
            3'd2:    key_limit = LIM_E4;
            3'd3:    key_limit = LIM_F4;
            3'd4:    key_limit = LIM_G4;
            3'd5:    key_limit = LIM_A4;
            3'd6:    key_limit = LIM_B4;
            default: key_limit = LIM_C5;
        endcase
    end

    always_comb begin
        state_d = state_q;
        brk_d   = brk_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        tone_d  = tone_q;

        if (state_q == S_PLAY && enable) begin
            if (cnt_q < limit_q - CW'(1)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end
        end else begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end

        // Key events override the counter update; a same-key repeat leaves the phase alone.
        if (code_valid) begin
            if (code == CODE_BREAK) begin
                brk_d = 1'b1;
            end else if (code == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (ext_q) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
            end else if (brk_q) begin
                brk_d = 1'b0;
                if (state_q == S_PLAY && key_hit && key_idx == idx_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    tone_d  = 1'b0;
                end
            end else if (key_hit && (state_q == S_IDLE || key_idx != idx_q)) begin
                state_d = S_PLAY;
                idx_d   = key_idx;
                limit_d = key_limit;
                cnt_d   = '0;
                tone_d  = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            brk_q   <= 1'b0;
            ext_q   <= 1'b0;
            idx_q   <= 3'd0;
            limit_q <= '0;
            cnt_q   <= '0;
            tone_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            brk_q   <= brk_d;
            ext_q   <= ext_d;
            idx_q   <= idx_d;
            limit_q <= limit_d;
            cnt_q   <= cnt_d;
            tone_q  <= tone_d;
        end
    end

    assign tone        = tone_q;
    assign note_active = (state_q == S_PLAY);
    assign note_idx    = idx_q;

endmodule

// File: tb/tb_key_tone_sequencer.sv
// Directed bench for key_tone_sequencer at CLK_HZ=500_000 (half-period limits scaled 1/100).
module tb_key_tone_sequencer;

    // Hand-rounded round(500_000 / (2*f)) for the notes used.
    localparam int L_C4 = 956;
    localparam int L_F4 = 716;
    localparam int L_A4 = 568;
    localparam int L_C5 = 478;

    logic       clk;
    logic       rst;
    logic [7:0] code;
    logic       code_valid;
    logic       enable;
    logic       tone;
    logic       note_active;
    logic [2:0] note_idx;

    int n_vec;
    int n_err;

    key_tone_sequencer #(.CLK_HZ(500_000), .CW(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .code        (code),
        .code_valid  (code_valid),
        .enable      (enable),
        .tone        (tone),
        .note_active (note_active),
        .note_idx    (note_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        tick(1);
        code_valid = 1'b0;
    endtask

    // Cycles until tone reaches lvl; returns max_cyc on timeout.
    task automatic wait_level(input logic lvl, input int max_cyc, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (tone !== lvl && n < max_cyc);
    endtask

    int n;
    int highs;
    int rises;
    int rise_at[4];
    logic prev;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; code = 8'h00; code_valid = 1'b0; enable = 1'b1;
        tick(3);
        check("rst_tone", int'(tone), 0);
        check("rst_active", int'(note_active), 0);
        check("rst_idx", int'(note_idx), 0);
        rst = 1'b0;
        tick(2);

        // Single key, full period
        send(8'h1C);
        check("t1_active", int'(note_active), 1);
        check("t1_idx", int'(note_idx), 0);
        check("t1_tone0", int'(tone), 0);
        wait_level(1'b1, 3000, n);
        check("t1_rise", n, L_C4);
        wait_level(1'b0, 3000, n);
        check("t1_fall", n, L_C4);

        // Break stops the note
        send(8'hF0);
        check("t2_brk_pending", int'(note_active), 1);
        send(8'h1C);
        check("t2_active", int'(note_active), 0);
        check("t2_tone", int'(tone), 0);
        check("t2_idx_hold", int'(note_idx), 0);
        highs = 0;
        repeat (1100) begin tick(1); highs += int'(tone); end
        check("t2_silent", highs, 0);

        // Last key wins; break of a non-active key is ignored
        send(8'h1C);
        tick(300);
        send(8'h42);
        check("t3_idx", int'(note_idx), 7);
        check("t3_tone0", int'(tone), 0);
        wait_level(1'b1, 3000, n);
        check("t3_rise", n, L_C5);
        send(8'hF0);
        send(8'h1C);
        check("t3_still_active", int'(note_active), 1);
        check("t3_still_idx", int'(note_idx), 7);
        send(8'hF0);
        send(8'h42);
        check("t3_stop", int'(note_active), 0);
        check("t3_stop_tone", int'(tone), 0);

        // Typematic repeats keep the phase, including one on a wrap edge
        send(8'h33);
        wait_level(1'b1, 3000, n);
        check("t4_rise", n, L_A4);
        rises = 0;
        prev  = tone;
        for (int c = 1; c <= 4 * 2 * L_A4; c++) begin
            if (c == 4 * 2 * L_A4) begin
                code = 8'h3B; code_valid = 1'b1;
            end else if (c % 1000 == 0 || c == 2 * 2 * L_A4) begin
                code = 8'h33; code_valid = 1'b1;
            end else begin
                code_valid = 1'b0;
            end
            tick(1);
            code_valid = 1'b0;
            if (!prev && tone && rises < 4) begin
                rise_at[rises] = c;
                rises++;
            end
            prev = tone;
        end
        check("t4_rises", rises, 3);
        check("t4_p1", rise_at[0], 2 * L_A4);
        check("t4_p2", rise_at[1] - rise_at[0], 2 * L_A4);
        check("t4_p3", rise_at[2] - rise_at[1], 2 * L_A4);
        check("t4_newkey_idx", int'(note_idx), 6);
        check("t4_newkey_tone", int'(tone), 0);
        send(8'hF0);
        send(8'h3B);
        check("t4_stop", int'(note_active), 0);

        // Extended and broken unmapped sequences start nothing
        send(8'hE0);
        send(8'h1C);
        check("t5_ext_ignored", int'(note_active), 0);
        send(8'hF0);
        send(8'h15);
        check("t5_brk_unmapped", int'(note_active), 0);
        check("t5_tone", int'(tone), 0);
        send(8'h1C);
        check("t5_flags_clear", int'(note_active), 1);
        send(8'hF0);
        send(8'h1C);
        check("t5_stop", int'(note_active), 0);

        // Mute and re-enable, then asynchronous reset mid-note
        send(8'h2B);
        check("t6_idx", int'(note_idx), 3);
        wait_level(1'b1, 3000, n);
        check("t6_rise", n, L_F4);
        tick(200);
        enable = 1'b0;
        highs = 0;
        repeat (10) begin tick(1); highs += int'(tone); end
        check("t6_muted", highs, 0);
        check("t6_mute_active", int'(note_active), 1);
        enable = 1'b1;
        wait_level(1'b1, 3000, n);
        check("t6_reenable", n, L_F4);
        tick(300);
        check("t6_pre_rst_tone", int'(tone), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_tone", int'(tone), 0);
        check("t6_rst_active", int'(note_active), 0);
        check("t6_rst_idx", int'(note_idx), 0);
        tick(1);
        rst = 1'b0;
        tick(L_F4 + 5);
        check("t6_post_rst_idle", int'(note_active), 0);
        check("t6_post_rst_tone", int'(tone), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
